// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result buffer: entry layout, FSM encoding,
// default widths and the balance-bit function used by the ALU.
package alu_pkg;

  localparam int DEF_RES_W = 32;
  localparam int DEF_PAR_W = 10;

  localparam logic [5:0] OP_MUL = 6'b000100;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [5:0]           opcode;
    logic [DEF_RES_W-1:0] result;
    logic                 balancebit;
    logic                 parity_ok;
  } alu_entry_t;

  // Value the head register shows after reset: all zero, but parity reported good.
  localparam alu_entry_t ENTRY_RESET = '{opcode: 6'd0, result: '0, balancebit: 1'b0, parity_ok: 1'b1};

  // 1 iff the number of set bits is even (matches the ALU's balance bit).
  function automatic logic even_balance(input logic [DEF_PAR_W-1:0] bits);
    return ~^bits;
  endfunction

endpackage

// File: rtl/alu_result_fifo_mem.sv
// Entry storage for the ALU result buffer: DEPTH-entry register array with one write
// port and a registered head-of-queue read that forwards a write aimed at the next head.
module alu_result_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  alu_entry_t       wdata,
  input  logic             head_load,
  input  logic [PTR_W-1:0] head_addr,
  output alu_entry_t       head
);

  alu_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A push into an empty queue lands on the next head slot in the same edge,
  // so the incoming word is forwarded rather than read from the stale array.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= ENTRY_RESET;
    end else if (head_load) begin
      head <= (we && (waddr == head_addr)) ? wdata : mem[head_addr];
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// FIFO stage behind the ALU multiplier: stores result/opcode/balance bit, re-checks parity,
// and hands entries on via valid/ready. ALU_RESULT_STATS_EN adds push/parity-error counters.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RES_W = DEF_RES_W,
  parameter int PAR_W = DEF_PAR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [5:0]                 in_opcode,
  input  logic [RES_W-1:0]           in_result,
  input  logic                       in_balancebit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 out_opcode,
  output logic [RES_W-1:0]           out_result,
  output logic                       out_balancebit,
  output logic                       out_parity_ok,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       parity_err,
  input  logic                       err_clr,
  output logic [1:0]                 ctrl_state
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [15:0]                stat_accepted,
  output logic [15:0]                stat_perr
`endif
);

  // Handshake: a word moves on an edge where its valid and ready are both high;
  // valid never waits on ready, and out_* hold steady while out_valid && !out_ready.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  ctrl_state_t      state, state_next;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [LVL_W-1:0] level_next;
  logic             push, pop, parity_ok;
  alu_entry_t       wr_entry, head;

  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign parity_ok   = (in_balancebit == even_balance(in_result[PAR_W-1:0]));
  assign rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign level_next  = level + LVL_W'(push) - LVL_W'(pop);

  assign wr_entry = '{opcode: in_opcode, result: in_result, balancebit: in_balancebit,
                      parity_ok: parity_ok};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY:   if (push) state_next = ST_PARTIAL;
      ST_PARTIAL: begin
        if (push && !pop && level == LVL_W'(DEPTH - 1)) state_next = ST_FULL;
        else if (pop && !push && level == LVL_W'(1))    state_next = ST_EMPTY;
      end
      ST_FULL:    if (pop) state_next = ST_PARTIAL;
      default:    state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state != ST_EMPTY);
    in_ready  = (state != ST_FULL);
  end

  assign ctrl_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_next;
      level  <= level_next;
    end
  end

  // Set wins over clear so a corrupt word arriving during err_clr is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (push && !parity_ok) begin
      parity_err <= 1'b1;
    end else if (err_clr) begin
      parity_err <= 1'b0;
    end
  end

  alu_result_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .we        (push),
    .waddr     (wr_ptr),
    .wdata     (wr_entry),
    .head_load (level_next != '0),
    .head_addr (rd_ptr_next),
    .head      (head)
  );

  assign out_opcode     = head.opcode;
  assign out_result     = head.result;
  assign out_balancebit = head.balancebit;
  assign out_parity_ok  = head.parity_ok;

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_perr     <= '0;
    end else if (push) begin
      if (stat_accepted != 16'hFFFF) stat_accepted <= stat_accepted + 16'd1;
      if (!parity_ok && stat_perr != 16'hFFFF) stat_perr <= stat_perr + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: reset, parity checking, fill/drain, wrap
// under concurrent push/pop, and mid-operation reset. Stats ports with ALU_RESULT_STATS_EN.
module tb_alu_result_buffer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_result;
  logic        in_balancebit;
  logic        out_valid, out_ready;
  logic [5:0]  out_opcode;
  logic [31:0] out_result;
  logic        out_balancebit, out_parity_ok;
  logic [2:0]  level;
  logic        parity_err, err_clr;
  logic [1:0]  ctrl_state;
`ifdef ALU_RESULT_STATS_EN
  logic [15:0] stat_accepted, stat_perr;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  alu_result_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_opcode      (in_opcode),
    .in_result      (in_result),
    .in_balancebit  (in_balancebit),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_opcode     (out_opcode),
    .out_result     (out_result),
    .out_balancebit (out_balancebit),
    .out_parity_ok  (out_parity_ok),
    .level          (level),
    .parity_err     (parity_err),
    .err_clr        (err_clr),
    .ctrl_state     (ctrl_state)
`ifdef ALU_RESULT_STATS_EN
    ,
    .stat_accepted  (stat_accepted),
    .stat_perr      (stat_perr)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic push_one(input logic [5:0] op, input logic [31:0] res, input logic bb);
    in_valid      = 1'b1;
    in_opcode     = op;
    in_result     = res;
    in_balancebit = bb;
    tick();
    in_valid      = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] fill_w  [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
  logic        fill_bb [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_result = '0; in_balancebit = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_parity_err", parity_err, 0);
    check("rst_parity_ok", out_parity_ok, 1);
    check("rst_out_result", out_result, 0);
    check("rst_state", ctrl_state, 0);

    // 5*6 = 30, low bits popcount 4 -> balance bit 1
    push_one(OP_MUL, 32'h0000001E, 1'b1);
    check("mul_out_valid", out_valid, 1);
    check("mul_result", out_result, 32'h0000001E);
    check("mul_opcode", out_opcode, OP_MUL);
    check("mul_parity_ok", out_parity_ok, 1);
    check("mul_parity_err", parity_err, 0);
    check("mul_level", level, 1);
    pop_one();
    check("pop_out_valid", out_valid, 0);
    check("pop_level", level, 0);
    check("empty_hold", out_result, 32'h0000001E);

    // 0x3C1 has popcount 5 -> correct balance bit is 0
    push_one(OP_MUL, 32'hFFFFFFC1, 1'b0);
    check("neg_parity_ok", out_parity_ok, 1);
    check("neg_parity_err", parity_err, 0);
    pop_one();
    push_one(OP_MUL, 32'hFFFFFFC1, 1'b1);
    check("bad_parity_ok", out_parity_ok, 0);
    check("bad_balancebit", out_balancebit, 1);
    check("bad_parity_err", parity_err, 1);
    pop_one();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_parity_err", parity_err, 0);

    // corrupt push during err_clr, non-multiply opcode still stored
    err_clr = 1'b1;
    push_one(6'h2A, 32'h0000001E, 1'b0);
    err_clr = 1'b0;
    check("setwins_parity_err", parity_err, 1);
    check("other_opcode", out_opcode, 6'h2A);
    pop_one();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr2_parity_err", parity_err, 0);

    // fill to DEPTH with consumer stalled
    for (int i = 0; i < 4; i++) begin
      push_one(OP_MUL, fill_w[i], fill_bb[i]);
      exp_q.push_back(fill_w[i]);
    end
    check("full_level", level, 4);
    check("full_in_ready", in_ready, 0);
    check("full_state", ctrl_state, 2);
    in_valid = 1'b1; in_result = 32'd5; in_balancebit = 1'b0;
    tick();
    check("full_reject_level", level, 4);
    check("full_head", out_result, exp_q[0]);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    check("pop_full_level", level, 3);
    check("pop_full_in_ready", in_ready, 1);
    while (exp_q.size() > 0) begin
      check("drain_order", out_result, exp_q[0]);
      tick();
      void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_level", level, 0);
    check("drain_parity_err", parity_err, 0);

    // steady push+pop at level 2 across pointer wrap
    push_one(OP_MUL, 32'hA0, ~^(10'h0A0));
    push_one(OP_MUL, 32'hA1, ~^(10'h0A1));
    exp_q.push_back(32'hA0);
    exp_q.push_back(32'hA1);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] w;
      w = 32'hB0 + 32'(i);
      in_valid = 1'b1; in_opcode = OP_MUL; in_result = w; in_balancebit = ~^w[9:0];
      out_ready = 1'b1;
      check("conc_head", out_result, exp_q[0]);
      check("conc_level", level, 2);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(w);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("conc_end_level", level, 2);
    check("conc_end_head", out_result, exp_q[0]);
    push_one(OP_MUL, 32'hC0, ~^(10'h0C0));
    check("pre_rst_level", level, 3);
    check("pre_rst_parity_err", parity_err, 0);
`ifdef ALU_RESULT_STATS_EN
    check("stat_accepted", stat_accepted, 21);
    check("stat_perr", stat_perr, 2);
`endif

    // reset with traffic in flight
    rst = 1'b1; in_valid = 1'b1; in_result = 32'hDEAD; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    check("mid_rst_level", level, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_result", out_result, 0);
`ifdef ALU_RESULT_STATS_EN
    check("rst_stat_accepted", stat_accepted, 0);
    check("rst_stat_perr", stat_perr, 0);
`endif
    push_one(OP_MUL, 32'h00000007, 1'b0);
    check("post_rst_head", out_result, 32'h00000007);
    check("post_rst_level", level, 1);
    check("post_rst_parity_ok", out_parity_ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
